// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - md_op_e    : operation encoding as issued by the decode stage
//   - md_state_e : sequencer FSM states
//   - md_signs_t : result sign flags recorded during PREP
//   - helpers that classify an operation (divide? signed?)
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_PREP = 2'b01,
    MD_RUN  = 2'b10,
    MD_FIX  = 2'b11
  } md_state_e;

  // Sign of each result, captured from the operand signs before iterating
  // on magnitudes.
  typedef struct packed {
    logic prod;  // sign(a) ^ sign(b)
    logic quo;   // sign(a) ^ sign(b)
    logic rem;   // sign(a): remainder follows the dividend
  } md_signs_t;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage : muldiv_sequencer_pkg

// File: rtl/muldiv_sequencer_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational radix-2 iteration of the multiply/divide datapath.
//
//   Multiply (div_mode_i = 0): shift-add, LSB first. acc_lo holds the
//     not-yet-consumed multiplier bits; each step conditionally adds the
//     multiplicand to acc_hi, then shifts the whole 64-bit pair right.
//   Divide (div_mode_i = 1): restoring, MSB first. acc_lo starts with the
//     dividend and fills with quotient bits; acc_hi is the partial remainder.
//
// Ports
//   acc_i      [2*XLEN-1:0] : current {acc_hi, acc_lo}
//   operand_i  [XLEN-1:0]   : multiplicand magnitude or divisor magnitude
//   div_mode_i              : 1 = divide iteration, 0 = multiply iteration
//   acc_o      [2*XLEN-1:0] : next {acc_hi, acc_lo}
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              div_mode_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] trial;
  logic            ge;

  assign acc_hi = acc_i[2*XLEN-1:XLEN];
  assign acc_lo = acc_i[XLEN-1:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one holding its old value and infer a latch.
    sum    = '0;
    rem_sh = '0;
    trial  = '0;
    ge     = 1'b0;
    acc_o  = acc_i;

    if (div_mode_i) begin
      // Bring the next dividend bit into the remainder. The shifted value
      // can need XLEN+1 bits, but since remainder < divisor, a successful
      // subtraction always fits back into XLEN bits.
      rem_sh = {acc_hi, acc_lo[XLEN-1]};
      ge     = (rem_sh >= {1'b0, operand_i});
      trial  = rem_sh[XLEN-1:0] - operand_i;
      acc_o  = {(ge ? trial : rem_sh[XLEN-1:0]), acc_lo[XLEN-2:0], ge};
    end else begin
      // Carry out of the add becomes the new MSB after the right shift.
      sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_i} : '0);
      acc_o = {sum, acc_lo[XLEN-1:1]};
    end
  end

endmodule : muldiv_step

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MULT/MULTU/DIV/DIVU unit for the MIPS32 core; owns HI/LO and
// serves MTHI/MTLO/MFHI/MFLO. An operation takes 34 cycles of busy:
// PREP (1) + RUN (XLEN) + FIX (1). HI/LO keep their old values until FIX.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   start, op[1:0]       : issue operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b         : rs (multiplicand/dividend), rt (multiplier/divisor)
//   mthi, mtlo, mt_data  : move-to HI/LO (honoured only when idle)
//   mf_req               : MFHI/MFLO in decode needs HI/LO
//   busy                 : operation in flight
//   stall                : busy & any HI/LO-touching request (combinational)
//   done                 : one-cycle pulse during FIX
//   hi, lo               : HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] mt_data,
  input  logic            mf_req,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q;
  md_op_e            op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   oper_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  md_signs_t         signs_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              busy_q;
  logic              done_q;

  logic              op_div;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  md_signs_t         signs_d;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;

  // Magnitudes and sign flags from the latched operands; used in PREP.
  assign op_div = op_is_div(op_q);
  assign a_neg  = op_is_signed(op_q) & a_q[XLEN-1];
  assign b_neg  = op_is_signed(op_q) & b_q[XLEN-1];
  assign a_abs  = a_neg ? -a_q : a_q;
  assign b_abs  = b_neg ? -b_q : b_q;

  assign signs_d.prod = a_neg ^ b_neg;
  assign signs_d.quo  = a_neg ^ b_neg;
  assign signs_d.rem  = a_neg;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i      (acc_q),
    .operand_i  (oper_q),
    .div_mode_i (op_div),
    .acc_o      (acc_d)
  );

  // Sign fix-up and result routing, committed to HI/LO in FIX.
  always_comb begin
    hi_d = acc_q[2*XLEN-1:XLEN];
    lo_d = acc_q[XLEN-1:0];
    if (!op_div) begin
      {hi_d, lo_d} = signs_q.prod ? -acc_q : acc_q;
    end else if (b_q == '0) begin
      // Divide by zero: fixed pattern, dividend passed through untouched.
      hi_d = a_q;
      lo_d = '1;
    end else begin
      hi_d = signs_q.rem ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      lo_d = signs_q.quo ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      oper_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      signs_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          // Move-to writes land at this edge; a simultaneous start will
          // overwrite both registers when it finishes.
          if (mthi) hi_q <= mt_data;
          if (mtlo) lo_q <= mt_data;
          if (start) begin
            op_q    <= md_op_e'(op);
            a_q     <= src_a;
            b_q     <= src_b;
            busy_q  <= 1'b1;
            state_q <= MD_PREP;
          end
        end

        MD_PREP: begin
          // Multiply: acc_lo carries the multiplier, oper_q the multiplicand.
          // Divide:   acc_lo carries the dividend,   oper_q the divisor.
          signs_q <= signs_d;
          acc_q   <= {{XLEN{1'b0}}, (op_div ? a_abs : b_abs)};
          oper_q  <= op_div ? b_abs : a_abs;
          cnt_q   <= CW'(XLEN - 1);
          state_q <= MD_RUN;
        end

        MD_RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= MD_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        MD_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end

        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (start | mthi | mtlo | mf_req);

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Table-driven vectors for MULT/MULTU/DIV/DIVU with hand-computed HI/LO,
// plus hand-written sequences for stall/collision, start+move-to, reset
// abort and move-to latency.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] mt_data;
  logic            mf_req;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mt_data (mt_data),
    .mf_req  (mf_req),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  // Issue one operation at the next negedge and follow it to completion.
  // Returns with the bench at the negedge after the commit edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int dones);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; dones = 0;
    while (busy && cyc < 100) begin
      if (done) dones++;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;

    vecs[0] = '{"mult_neg3x7",      MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"multu_max",        MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"div_neg7_2",       MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"div_minint_neg1",  MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{"divu_100_0",       MD_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[5] = '{"divu_100_7",       MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{"div_7_neg2",       MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{"mult_minint_sq",   MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{"div_neg5_0",       MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9] = '{"multu_shift4",     MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};

    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    mthi = 1'b0; mtlo = 1'b0; mt_data = '0; mf_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_hi",   hi,   0);
    check("reset_lo",   lo,   0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Idle MFHI must not stall.
    mf_req = 1'b1;
    #1 check("idle_stall", stall, 0);
    mf_req = 1'b0;

    // ---- table-driven operations (issued back to back) ----
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, dones);
      check({vecs[i].name, "_busy_cycles"}, 64'(cyc), 34);
      check({vecs[i].name, "_done_pulses"}, 64'(dones), 1);
      check({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].lo);
    end

    // ---- MTHI and MTLO together, 1-edge latency ----
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h5555AAAA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'h5555AAAA);
    check("mt_both_lo", lo, 32'h5555AAAA);

    // ---- collisions during an operation ----
    start = 1'b1; op = MD_MULT; src_a = 32'hFFFFFFFD; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; dones = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) dones++;
      if (cyc == 5) begin
        mf_req = 1'b1;
        #1 check("coll_stall_mf", stall, 1);
      end
      if (cyc == 10) begin
        start = 1'b1; op = MD_MULTU; src_a = 32'd3; src_b = 32'd3;
        mthi = 1'b1; mt_data = 32'h1234;
        #1 check("coll_stall_start_mthi", stall, 1);
        check("coll_hi_held", hi, 32'h5555AAAA);
        check("coll_lo_held", lo, 32'h5555AAAA);
      end
      @(negedge clk);
      mf_req = 1'b0; start = 1'b0; mthi = 1'b0;
    end
    check("coll_busy_cycles", 64'(cyc), 34);
    check("coll_done_pulses", 64'(dones), 1);
    check("coll_hi", hi, 32'hFFFFFFFF);
    check("coll_lo", lo, 32'hFFFFFFEB);
    repeat (3) @(negedge clk);
    check("coll_no_second_op", busy, 0);
    check("coll_hi_after", hi, 32'hFFFFFFFF);

    // ---- start and MTHI in the same idle cycle ----
    start = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    mthi = 1'b1; mt_data = 32'hABCD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    check("st_mt_busy", busy, 1);
    check("st_mt_hi_landed", hi, 32'hABCD);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("st_mt_cycles", 64'(cyc), 34);
    check("st_mt_hi", hi, 32'd2);
    check("st_mt_lo", lo, 32'd14);

    // ---- reset in RUN cycle 17 aborts the operation ----
    start = 1'b1; op = MD_MULTU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    // Cycle 1 is PREP, so RUN cycle 17 is busy cycle 18.
    repeat (17) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0; cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) cyc++;
    end
    check("abort_no_done", 64'(dones), 0);
    check("abort_no_busy", 64'(cyc), 0);
    check("abort_hi_after", hi, 0);

    // ---- MTLO after reset ----
    mtlo = 1'b1; mt_data = 32'hCAFEF00D;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hCAFEF00D);
    check("mtlo_hi_untouched", hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_muldiv_sequencer
